// File: rtl/acorn128_pkg.sv
// Shared types and word-index constants for the ACORN-128 stream front end.
package acorn128_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, CLEAR} state_t;

   localparam int LOAD_WORDS     = 18;
   localparam int LOAD_WORDS_CHK = 22;
   localparam int OUT_WORDS      = 8;

   localparam int KEY_W0 = 0;
   localparam int IV_W0  = 4;
   localparam int AD_W0  = 8;
   localparam int TXT_W0 = 12;
   localparam int LEN_W0 = 16;
   localparam int TAG_W0 = 18;

   // Index of the final input word; decrypt with tag check carries 4 extra words.
   function automatic logic [4:0] last_word(input logic chk_dec);
      return chk_dec ? 5'(LOAD_WORDS_CHK - 1) : 5'(LOAD_WORDS - 1);
   endfunction

endpackage

// File: rtl/acorn128_stream_if_if.sv
// 32-bit valid/ready input and output streams of the ACORN-128 front end.
interface acorn128_stream_bus;
   logic [31:0] s_data_i;
   logic        s_valid_i;
   logic        s_ready_o;
   logic        mode_enc_i;
   logic [31:0] m_data_o;
   logic        m_valid_o;
   logic        m_ready_i;
   logic        m_last_o;

   modport master (
      output s_data_i, s_valid_i, mode_enc_i, m_ready_i,
      input  s_ready_o, m_data_o, m_valid_o, m_last_o
   );

   modport slave (
      input  s_data_i, s_valid_i, mode_enc_i, m_ready_i,
      output s_ready_o, m_data_o, m_valid_o, m_last_o
   );
endinterface

// File: rtl/acorn128_word_ser.sv
// 256-bit parallel-load serializer: emits the low 32-bit word first, flags the final word.
module acorn128_word_ser (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [255:0] data,
   input  logic [3:0]   words,
   output logic [31:0]  word,
   output logic         valid,
   input  logic         ready,
   output logic         last,
   output logic         done
);

   logic [255:0] shreg;
   logic [3:0]   left;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
         left  <= '0;
         valid <= 1'b0;
      end else if (load) begin
         shreg <= data;
         left  <= words;
         valid <= (words != 4'd0);
      end else if (valid && ready) begin
         shreg <= {32'b0, shreg[255:32]};
         left  <= left - 4'd1;
         if (left == 4'd1)
            valid <= 1'b0;
      end
   end

   assign word = shreg[31:0];
   assign last = valid && (left == 4'd1);
   assign done = valid && ready && (left == 4'd1);

endmodule

// File: rtl/acorn128_stream_if.sv
// Valid/ready front end for acorn128_top: word assembly, core sequencing, result/tag drain.
// Optional feature macro: ACORN_TAG_CHECK_EN (decrypt loads an expected tag and checks it).
module acorn128_stream_if
   import acorn128_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 8192,
   parameter int CLR_CYCLES     = 2
) (
   input  logic                clk,
   input  logic                rst,
   acorn128_stream_bus.slave   bus,
   output logic                core_start_o,
   output logic                core_enc_o,
   output logic                core_clr_o,
   output logic [127:0]        core_key_o,
   output logic [127:0]        core_iv_o,
   output logic [127:0]        core_text_o,
   output logic [127:0]        core_ad_o,
   output logic [63:0]         core_len_o,
   input  logic                core_ready_i,
   input  logic [127:0]        core_res_i,
   input  logic [127:0]        core_tag_i,
   output logic                busy_o,
   output logic                err_timeout_o,
   output logic                tag_ok_o
);

   localparam int  TW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int  CW    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
   localparam bit  TO_EN = (TIMEOUT_CYCLES != 0);

   state_t          state;
   logic [4:0]      cnt;
   logic [TW-1:0]   tcnt;
   logic [CW-1:0]   ccnt;
   logic            s_ready;
   logic            accept;
   logic            chk_dec;
   logic            tag_match;
   logic            ready_seen;
   logic            to_hit;
   logic [1:0]      tag_sel;
   logic            ser_load;
   logic [255:0]    ser_data;
   logic [3:0]      ser_words;
   logic            ser_done;

`ifdef ACORN_TAG_CHECK_EN
   logic [127:0]    exp_tag;
   assign chk_dec   = !((state == IDLE) ? bus.mode_enc_i : core_enc_o);
   assign tag_match = (core_tag_i == exp_tag);
`else
   assign chk_dec   = 1'b0;
   assign tag_match = 1'b0;
`endif

   assign accept     = bus.s_valid_i && s_ready;
   assign tag_sel    = cnt[1:0] - 2'(TAG_W0);
   // A ready already high on RUN entry belongs to the previous message.
   assign ready_seen = core_ready_i && (tcnt != '0);
   assign to_hit     = TO_EN && (tcnt == TW'(TIMEOUT_CYCLES - 1));
   assign ser_load   = (state == RUN) && ready_seen;
   assign busy_o     = (state != IDLE);
   assign bus.s_ready_o = s_ready;

   always_comb begin
      ser_words = 4'(OUT_WORDS);
      ser_data  = {core_tag_i, core_res_i};
      if (chk_dec) begin
         ser_words = 4'(OUT_WORDS / 2);
         ser_data  = {128'b0, tag_match ? core_res_i : 128'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         tcnt          <= '0;
         ccnt          <= '0;
         s_ready       <= 1'b0;
         core_start_o  <= 1'b0;
         core_enc_o    <= 1'b0;
         core_clr_o    <= 1'b0;
         core_key_o    <= '0;
         core_iv_o     <= '0;
         core_text_o   <= '0;
         core_ad_o     <= '0;
         core_len_o    <= '0;
         err_timeout_o <= 1'b0;
         tag_ok_o      <= 1'b0;
`ifdef ACORN_TAG_CHECK_EN
         exp_tag       <= '0;
`endif
      end else begin
         if (accept) begin
            if (cnt < 5'(IV_W0))
               core_key_o[{cnt[1:0], 5'b0} +: 32] <= bus.s_data_i;
            else if (cnt < 5'(AD_W0))
               core_iv_o[{cnt[1:0], 5'b0} +: 32] <= bus.s_data_i;
            else if (cnt < 5'(TXT_W0))
               core_ad_o[{cnt[1:0], 5'b0} +: 32] <= bus.s_data_i;
            else if (cnt < 5'(LEN_W0))
               core_text_o[{cnt[1:0], 5'b0} +: 32] <= bus.s_data_i;
            else if (cnt < 5'(TAG_W0))
               core_len_o[{cnt[0], 5'b0} +: 32] <= bus.s_data_i;
`ifdef ACORN_TAG_CHECK_EN
            else
               exp_tag[{tag_sel, 5'b0} +: 32] <= bus.s_data_i;
`endif
         end

         unique case (state)
            IDLE: begin
               s_ready <= 1'b1;
               if (accept) begin
                  core_enc_o    <= bus.mode_enc_i;
                  err_timeout_o <= 1'b0;
                  tag_ok_o      <= 1'b0;
                  cnt           <= 5'd1;
                  state         <= LOAD;
               end
            end
            LOAD: begin
               if (accept) begin
                  cnt <= cnt + 5'd1;
                  if (cnt == last_word(chk_dec)) begin
                     s_ready      <= 1'b0;
                     core_start_o <= 1'b1;
                     tcnt         <= '0;
                     state        <= RUN;
                  end
               end
            end
            RUN: begin
               if (tcnt != '1)
                  tcnt <= tcnt + 1'b1;
               if (ready_seen) begin
                  core_start_o <= 1'b0;
                  tag_ok_o     <= chk_dec && tag_match;
                  state        <= DRAIN;
               end else if (to_hit) begin
                  core_start_o  <= 1'b0;
                  err_timeout_o <= 1'b1;
                  core_clr_o    <= 1'b1;
                  ccnt          <= '0;
                  state         <= CLEAR;
               end
            end
            DRAIN: begin
               if (ser_done) begin
                  core_clr_o <= 1'b1;
                  ccnt       <= '0;
                  state      <= CLEAR;
               end
            end
            CLEAR: begin
               if (ccnt == CW'(CLR_CYCLES - 1)) begin
                  core_clr_o <= 1'b0;
                  s_ready    <= 1'b1;
                  cnt        <= '0;
                  state      <= IDLE;
               end else begin
                  ccnt <= ccnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   acorn128_word_ser u_ser (
      .clk   (clk),
      .rst   (rst),
      .load  (ser_load),
      .data  (ser_data),
      .words (ser_words),
      .word  (bus.m_data_o),
      .valid (bus.m_valid_o),
      .ready (bus.m_ready_i),
      .last  (bus.m_last_o),
      .done  (ser_done)
   );

endmodule
